// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared RAM geometry, requester IDs and read-owner encoding
package mem_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 32;

    localparam int REQ_CPU = 0;
    localparam int REQ_IO  = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_0    = 2'b01,
        OWN_1    = 2'b10
    } owner_e;

    // Owner of the read issued this cycle; writes and idle cycles own nothing.
    function automatic owner_e read_owner(input logic [1:0] gnt, input logic we0, input logic we1);
        owner_e own;
        own = OWN_NONE;
        if (gnt[REQ_CPU] && !we0) begin
            own = OWN_0;
        end else if (gnt[REQ_IO] && !we1) begin
            own = OWN_1;
        end
        return own;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational picker with last-grant pointer, one-hot grant
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie, round-robin favours whoever was not served last.
            2'b11:   gnt = (RR_EN && !last_gnt) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter and sequencer for the shared single-port RAM
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic       ptr_q, ptr_d;
    owner_e     owner_q, owner_d;
    logic [1:0] req_vec;
    logic [1:0] gnt_vec;

    assign req_vec = {req1, req0};

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req      (req_vec),
        .last_gnt (ptr_q),
        .gnt      (gnt_vec)
    );

    always_comb begin
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ptr_d     = ptr_q;
        owner_d   = read_owner(gnt_vec, we0, we1);
        if (gnt_vec[REQ_CPU]) begin
            ram_addr  = addr0;
            ram_wdata = wdata0;
            ram_write = we0;
            ram_read  = !we0;
            ptr_d     = 1'b0;
        end else if (gnt_vec[REQ_IO]) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
            ram_write = we1;
            ram_read  = !we1;
            ptr_d     = 1'b1;
        end
    end

    // Pointer resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 1'b1;
            owner_q <= OWN_NONE;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // The owner register is one-hot, so its bits are the rvalid flops themselves.
    assign gnt0    = gnt_vec[REQ_CPU];
    assign gnt1    = gnt_vec[REQ_IO];
    assign rvalid0 = (owner_q == OWN_0);
    assign rvalid1 = (owner_q == OWN_1);
    assign rdata   = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed scoreboard bench for ram_arbiter (round-robin and fixed-priority)
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        gnt0, gnt1, rvalid0, rvalid1, ram_read, ram_write;
    logic [8:0]  ram_addr;
    logic [31:0] rdata, ram_wdata, ram_data_out;

    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_ram_read, f_ram_write;
    logic [8:0]  f_ram_addr;
    logic [31:0] f_rdata, f_ram_wdata, f_ram_data_out;

    logic [31:0] ram_mem [0:511];
    logic [31:0] ref_mem [0:511];
    logic        prev_rd0, prev_rd1;
    logic [32:0] sb [$];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_data_out(ram_data_out)
    );

    ram_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
        .rdata(f_rdata), .ram_read(f_ram_read), .ram_write(f_ram_write),
        .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_data_out(f_ram_data_out)
    );

    assign f_ram_data_out = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model driven by the round-robin instance's pins.
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_data_out <= ram_mem[ram_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rd0 <= 1'b0;
            prev_rd1 <= 1'b0;
        end else begin
            prev_rd0 <= gnt0 & ~we0;
            prev_rd1 <= gnt1 & ~we1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_rw_excl", 64'(ram_read & ram_write), 64'd0);
            chk("inv_gnt_excl", 64'(gnt0 & gnt1), 64'd0);
            chk("inv_fp_gnt_excl", 64'(f_gnt0 & f_gnt1), 64'd0);
            chk("inv_rvalid0", 64'(rvalid0), 64'(prev_rd0));
            chk("inv_rvalid1", 64'(rvalid1), 64'(prev_rd1));
        end
    end

    // Drives one cycle of requests just after a falling edge and checks grants, pins and read return.
    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [8:0] a1, input logic [31:0] d1,
                        input logic [1:0] eg_rr, input logic [1:0] eg_fp);
        logic [32:0] ent;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        chk({tag, ":gnt_rr"}, 64'({gnt1, gnt0}), 64'(eg_rr));
        chk({tag, ":gnt_fp"}, 64'({f_gnt1, f_gnt0}), 64'(eg_fp));
        if (eg_rr == 2'b01) begin
            chk({tag, ":addr"}, 64'(ram_addr), 64'(a0));
            chk({tag, ":rw"}, 64'({ram_write, ram_read}), 64'({w0, ~w0}));
            if (w0) begin
                chk({tag, ":wdata"}, 64'(ram_wdata), 64'(d0));
                ref_mem[a0] = d0;
            end else sb.push_back({1'b0, ref_mem[a0]});
        end else if (eg_rr == 2'b10) begin
            chk({tag, ":addr"}, 64'(ram_addr), 64'(a1));
            chk({tag, ":rw"}, 64'({ram_write, ram_read}), 64'({w1, ~w1}));
            if (w1) begin
                chk({tag, ":wdata"}, 64'(ram_wdata), 64'(d1));
                ref_mem[a1] = d1;
            end else sb.push_back({1'b1, ref_mem[a1]});
        end else begin
            chk({tag, ":idle_pins"}, 64'({ram_write, ram_read, ram_addr, ram_wdata}), 64'd0);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            chk({tag, ":rvalid"}, 64'({rvalid1, rvalid0}), ent[32] ? 64'd2 : 64'd1);
            chk({tag, ":rdata"}, 64'(rdata), 64'(ent[31:0]));
        end else begin
            chk({tag, ":no_rvalid"}, 64'({rvalid1, rvalid0}), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_mem[9'h010] = 32'hA; ref_mem[9'h010] = 32'hA;
        ram_mem[9'h011] = 32'hB; ref_mem[9'h011] = 32'hB;
        for (int i = 0; i < 4; i++) begin
            ram_mem[i] = 32'h100 + 32'(i);
            ref_mem[i] = 32'h100 + 32'(i);
        end
        ram_data_out = 32'h0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rvalid", 64'({rvalid1, rvalid0, f_rvalid1, f_rvalid0}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_idle", 64'({gnt1, gnt0, ram_read, ram_write, ram_addr}), 64'd0);
        @(negedge clk);

        step("wr0",   1, 1, 9'h005, 32'hDEADBEEF, 0, 0, 9'h000, 32'h0, 2'b01, 2'b01);
        step("rd0",   1, 0, 9'h005, 32'h0,        0, 0, 9'h000, 32'h0, 2'b01, 2'b01);
        step("rd1",   0, 0, 9'h000, 32'h0,        1, 0, 9'h011, 32'h0, 2'b10, 2'b10);
        step("tie_a", 1, 0, 9'h010, 32'h0,        1, 0, 9'h011, 32'h0, 2'b01, 2'b01);
        step("tie_b", 1, 0, 9'h010, 32'h0,        1, 0, 9'h011, 32'h0, 2'b10, 2'b01);
        step("tie_c", 1, 0, 9'h010, 32'h0,        1, 0, 9'h011, 32'h0, 2'b01, 2'b01);
        step("tie_d", 1, 0, 9'h010, 32'h0,        1, 0, 9'h011, 32'h0, 2'b10, 2'b01);
        step("drop0", 0, 0, 9'h010, 32'h0,        1, 0, 9'h011, 32'h0, 2'b10, 2'b10);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("b2b%0d", i), 1, 0, 9'(i), 32'h0, 0, 0, 9'h000, 32'h0, 2'b01, 2'b01);
        end
        step("wr1_top", 0, 0, 9'h000, 32'h0,      1, 1, 9'h1FF, 32'h1234, 2'b10, 2'b10);
        step("rd0_top", 1, 0, 9'h1FF, 32'h0,      0, 0, 9'h000, 32'h0,    2'b01, 2'b01);
        step("tie_p0",  1, 0, 9'h010, 32'h0,      1, 0, 9'h011, 32'h0,    2'b10, 2'b01);
        step("idle",    0, 0, 9'h000, 32'h0,      0, 0, 9'h000, 32'h0,    2'b00, 2'b00);
        step("pre_rst", 1, 0, 9'h002, 32'h0,      0, 0, 9'h000, 32'h0,    2'b01, 2'b01);

        req0 = 1; we0 = 0; addr0 = 9'h005; req1 = 0;
        #1;
        chk("rst_mid:gnt", 64'({gnt1, gnt0}), 64'd1);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid:rvalid", 64'({rvalid1, rvalid0}), 64'd0);
        @(negedge clk);
        req0 = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_after:rvalid", 64'({rvalid1, rvalid0}), 64'd0);
        @(negedge clk);
        step("tie_post_rst", 1, 0, 9'h010, 32'h0, 1, 0, 9'h011, 32'h0, 2'b01, 2'b01);
        step("tie_post_rst2", 1, 0, 9'h010, 32'h0, 1, 0, 9'h011, 32'h0, 2'b10, 2'b01);
        step("end_idle", 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 2'b00, 2'b00);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 512x32 single-port synchronous RAM.
- The RAM registers reads: data_out is valid the cycle after read is asserted, and it holds its value otherwise.
- Requester 0 is the CPU memory stage; requester 1 is the I/O / program-loader port.
- The arbiter grants at most one access per cycle, drives the RAM control, address and data pins, and returns read data with a per-requester valid pulse. Sustained throughput is 1 access per cycle.

Parameters:
- ADDR_W, 9, RAM address width
- DATA_W, 32, RAM data width
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  access request, held until granted
- we0, we1  in  1 each  1 = write, 0 = read; valid while reqN is high
- addr0, addr1  in  ADDR_W each  access address
- wdata0, wdata1  in  DATA_W each  write data
- gnt0, gnt1  out  1 each  combinational; high in the cycle the request is accepted
- rvalid0, rvalid1  out  1 each  registered; high for one cycle when rdata belongs to that requester
- rdata  out  DATA_W  read data; direct from ram_data_out, meaningful only when an rvalid is high
- ram_read, ram_write  out  1 each  to RAM read/write pins; never both high
- ram_addr  out  ADDR_W  to RAM address_in
- ram_wdata  out  DATA_W  to RAM data_in
- ram_data_out  in  DATA_W  from RAM data_out

Behaviour:
- Reset (async assert, sync release): rvalid0/1=0, last-grant pointer=1 (so requester 0 wins the first tie), pending-read owner cleared. Combinational outputs then follow the rules below.
- Grant selection (combinational, every cycle):
  - Only one requesting: grant it.
  - Both requesting, RR_EN=1: grant the requester not granted most recently.
  - Both requesting, RR_EN=0: grant requester 0.
  - None requesting: no grant; ram_read=ram_write=0; ram_addr and ram_wdata are 0.
- Granted cycle N:
  - ram_addr = addrN and ram_wdata = wdataN.
  - ram_write = weN and ram_read = ~weN.
  - gntN = 1; the requester may change or drop its request from N+1 onward.
- Pointer update: the last-grant pointer updates at the end of every cycle with a grant. There is no update without a grant.
- Read latency: a read granted in cycle N gives rvalidN=1 in cycle N+1, with rdata = mem[addr] as sampled at N.
- Pipelining: a new grant is allowed in cycle N+1 while rvalid from N is high; back-to-back reads from either requester are supported.
- Write latency: write is complete at the end of cycle N. A read to the same address granted at N+1 returns the new data. No rvalid is produced for writes.
- Ungranted requester: sees gnt=0, must hold req/we/addr/wdata stable, and is guaranteed a grant within 2 cycles when RR_EN=1.
- Simultaneous events:
  - A requester granted a read at N and requesting again at N+1 may receive gnt and rvalid in the same cycle.
  - rvalid0 and rvalid1 are never high together.
- Reset mid-operation: any rvalid pending for the next cycle is dropped and is not replayed. Requesters must reissue.
- rdata while no rvalid is high: unspecified (RAM holds its last value); no bench check.
- No FSM beyond three registers: the pointer, the registered read owner (2 bits: none/0/1), and the rvalid flops. This block is flow control only and contains no storage for data.

Decomposition:
- Shared package mem_pkg:
  - RAM_ADDR_W=9, RAM_DATA_W=32
  - requester ID constants REQ_CPU=0, REQ_IO=1
  - owner encoding OWN_NONE=2'b00, OWN_0=2'b01, OWN_1=2'b10
- Sub-module rr_arb2: the 2-way combinational round-robin picker, with pointer input and one-hot grant output. It is reusable for other shared resources.
- The top level holds the pointer and owner registers and the RAM-side muxing. The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then req0 write addr=0x005 wdata=0xDEADBEEF → gnt0=1 same cycle, ram_write=1, ram_addr=0x005. Next cycle req0 read 0x005 → gnt0=1, rvalid0=1 next cycle, rdata=0xDEADBEEF.
- Both requesters read (0x010 / 0x011, preloaded 0xA / 0xB) held for 4 cycles, RR_EN=1 → grants alternate 0,1,0,1; rvalid alternates one cycle later; rdata 0xA,0xB,0xA,0xB.
- Same stimulus with RR_EN=0 → gnt0 every cycle, gnt1 never; gnt1=1 the first cycle req0 drops.
- Back-to-back: req0 reads 0x000..0x003 in consecutive cycles → 4 consecutive rvalid0 pulses, in order, with no bubbles.
- Write by req1 at 0x1FF (0x1234) at N, read by req0 at 0x1FF at N+1 → rvalid0 at N+2 with rdata=0x1234.
- Read granted at N, rst_n low asynchronously during N → rvalid0 stays 0; after release the pointer favours req0 on a tie.
- Assertions on all cycles:
  - ram_read & ram_write never both 1.
  - gnt0 & gnt1 never both 1.
  - rvalidN only in the cycle after a read grant to N.
